// File: rtl/avalon_st_pkg.sv
// Shared types and helpers for the Avalon-ST packet checker.
//   state_t   : checker FSM states
//   report_t  : per-packet report (length plus the three error flags)
//   lenw()    : width needed to hold 0..MAX_PKT_LEN
//   sat_inc() : saturating increment for the 16-bit report counters
package avalon_st_pkg;

  localparam int CNT_W     = 16;
  // Report length field is sized for MAX_PKT_LEN up to 65535.
  localparam int RPT_LEN_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    IN_PKT,
    DROP
  } state_t;

  typedef struct packed {
    logic [RPT_LEN_W-1:0] len;
    logic                 order;
    logic                 framing;
    logic                 length;
  } report_t;

  function automatic int lenw(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/avalon_st_pkt_checker_if.sv
// Avalon-ST beat bus between a packet source and the checker sink.
//   data / startofpacket / endofpacket / valid : driven by the source
//   ready                                      : driven by the sink
interface avalon_st_pkt_checker_if #(
  parameter int DWIDTH = 32
);

  logic [DWIDTH-1:0] data;
  logic              startofpacket;
  logic              endofpacket;
  logic              valid;
  logic              ready;

  modport master (
    output data, startofpacket, endofpacket, valid,
    input  ready
  );

  modport slave (
    input  data, startofpacket, endofpacket, valid,
    output ready
  );

endinterface

// File: rtl/avalon_st_ready_gen.sv
// Programmable backpressure generator.
//   clk_i        : clock
//   srst_n_i     : synchronous active-low reset
//   stall_mask_i : bit k = ready during phase k of an 8-cycle pattern
//   ready_o      : registered sink ready
module avalon_st_ready_gen (
  input  logic       clk_i,
  input  logic       srst_n_i,
  input  logic [7:0] stall_mask_i,
  output logic       ready_o
);

  logic [2:0] phase_q;

  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      phase_q <= '0;
      ready_o <= 1'b0;
    end else begin
      phase_q <= phase_q + 3'd1;
      ready_o <= stall_mask_i[phase_q];
    end
  end

endmodule

// File: rtl/avalon_st_pkt_checker.sv
// Avalon-ST sink that checks framing, non-decreasing unsigned order and
// length of every packet and publishes one registered report per packet.
//   clk_i, srst_n_i   : clock, synchronous active-low reset
//   snk               : Avalon-ST sink bus (slave modport)
//   stall_mask_i      : backpressure pattern for snk.ready
//   pkt_done_o        : one-cycle report strobe
//   pkt_len_o         : beats in reported packet (saturating)
//   pkt_ok_o          : reported packet had no error
//   err_order_o       : reported packet had a descending pair
//   err_framing_o     : reported packet had a framing error
//   err_len_o         : reported packet exceeded MAX_PKT_LEN
//   pkt_cnt_o         : reports issued (saturating)
//   err_cnt_o         : reports with pkt_ok_o=0 (saturating)
module avalon_st_pkt_checker
  import avalon_st_pkg::*;
#(
  parameter  int DWIDTH      = 32,
  parameter  int MAX_PKT_LEN = 1024,
  localparam int LENW        = lenw(MAX_PKT_LEN)
) (
  input  logic                  clk_i,
  input  logic                  srst_n_i,
  avalon_st_pkt_checker_if.slave snk,
  input  logic [7:0]            stall_mask_i,
  output logic                  pkt_done_o,
  output logic [LENW-1:0]       pkt_len_o,
  output logic                  pkt_ok_o,
  output logic                  err_order_o,
  output logic                  err_framing_o,
  output logic                  err_len_o,
  output logic [CNT_W-1:0]      pkt_cnt_o,
  output logic [CNT_W-1:0]      err_cnt_o
);

  localparam logic [LENW-1:0] LEN_MAX     = LENW'(MAX_PKT_LEN);
  localparam report_t         FRAMING_RPT = '{len: '0, order: 1'b0, framing: 1'b1, length: 1'b0};
  localparam report_t         SINGLE_RPT  = '{len: RPT_LEN_W'(1), order: 1'b0, framing: 1'b0, length: 1'b0};

  logic              snk_ready;
  logic [DWIDTH-1:0] data;
  logic              sop;
  logic              eop;
  logic              accept;

  state_t            state_q, state_d;
  logic [DWIDTH-1:0] prev_q, prev_d;
  logic [LENW-1:0]   len_q, len_d;
  logic              order_q, order_d;
  logic              lerr_q, lerr_d;
  logic              open_pkt;

  // Up to two reports can be produced by one accept (close + single-beat open).
  report_t           new_a, new_b;
  logic              new_a_vld, new_b_vld;
  report_t           pend_q, pend_d;
  logic              pend_vld_q, pend_vld_d;
  report_t           out_rpt;
  logic              out_vld;
  report_t           rpt_q;
  logic              rpt_len_unused;

  avalon_st_ready_gen u_ready_gen (
    .clk_i        (clk_i),
    .srst_n_i     (srst_n_i),
    .stall_mask_i (stall_mask_i),
    .ready_o      (snk_ready)
  );

  assign snk.ready = snk_ready;
  assign data      = snk.data;
  assign sop       = snk.startofpacket;
  assign eop       = snk.endofpacket;
  assign accept    = snk.valid & snk_ready;

  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    len_d     = len_q;
    order_d   = order_q;
    lerr_d    = lerr_q;
    open_pkt  = 1'b0;
    new_a_vld = 1'b0;
    new_a     = '0;
    new_b_vld = 1'b0;
    new_b     = '0;
    if (accept) begin
      unique case (state_q)
        IDLE: begin
          if (sop) begin
            open_pkt = 1'b1;
          end else if (eop) begin
            new_a_vld = 1'b1;
            new_a     = FRAMING_RPT;
          end else begin
            state_d = DROP;
          end
        end
        IN_PKT: begin
          if (sop) begin
            // Unterminated packet is closed with a framing error; the same
            // beat then opens the next packet.
            new_a_vld = 1'b1;
            new_a     = '{len: RPT_LEN_W'(len_q), order: order_q, framing: 1'b1, length: lerr_q};
            open_pkt  = 1'b1;
          end else begin
            order_d = order_q | (data < prev_q);
            prev_d  = data;
            if (len_q == LEN_MAX) begin
              lerr_d = 1'b1;
            end else begin
              len_d = len_q + LENW'(1);
            end
            if (eop) begin
              new_a_vld = 1'b1;
              new_a     = '{len: RPT_LEN_W'(len_d), order: order_d, framing: 1'b0, length: lerr_d};
              state_d   = IDLE;
            end
          end
        end
        DROP: begin
          if (sop) begin
            new_a_vld = 1'b1;
            new_a     = FRAMING_RPT;
            open_pkt  = 1'b1;
          end else if (eop) begin
            new_a_vld = 1'b1;
            new_a     = FRAMING_RPT;
            state_d   = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase

      if (open_pkt) begin
        prev_d  = data;
        len_d   = LENW'(1);
        order_d = 1'b0;
        lerr_d  = 1'b0;
        if (eop) begin
          state_d = IDLE;
          if (new_a_vld) begin
            new_b_vld = 1'b1;
            new_b     = SINGLE_RPT;
          end else begin
            new_a_vld = 1'b1;
            new_a     = SINGLE_RPT;
          end
        end else begin
          state_d = IN_PKT;
        end
      end
    end
  end

  // A double report can only come from IN_PKT/DROP, and leaving IDLE again
  // takes a non-reporting beat, so one pending slot never overflows.
  always_comb begin
    out_vld    = pend_vld_q | new_a_vld;
    out_rpt    = pend_vld_q ? pend_q : new_a;
    pend_vld_d = pend_vld_q ? new_a_vld : new_b_vld;
    pend_d     = pend_vld_q ? new_a : new_b;
  end

  // Stage p0 -> p1: control state, report registers and counters.
  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      state_q    <= IDLE;
      pend_vld_q <= 1'b0;
      pkt_done_o <= 1'b0;
      rpt_q      <= '0;
      pkt_ok_o   <= 1'b0;
      pkt_cnt_o  <= '0;
      err_cnt_o  <= '0;
    end else begin
      state_q    <= state_d;
      pend_vld_q <= pend_vld_d;
      pkt_done_o <= out_vld;
      if (out_vld) begin
        rpt_q     <= out_rpt;
        pkt_ok_o  <= ~(out_rpt.order | out_rpt.framing | out_rpt.length);
        pkt_cnt_o <= sat_inc(pkt_cnt_o);
        if (out_rpt.order | out_rpt.framing | out_rpt.length) begin
          err_cnt_o <= sat_inc(err_cnt_o);
        end
      end
    end
  end

  // Datapath registers: always rewritten when a packet opens, so no reset.
  always_ff @(posedge clk_i) begin
    prev_q  <= prev_d;
    len_q   <= len_d;
    order_q <= order_d;
    lerr_q  <= lerr_d;
    pend_q  <= pend_d;
  end

  assign pkt_len_o      = rpt_q.len[LENW-1:0];
  assign err_order_o    = rpt_q.order;
  assign err_framing_o  = rpt_q.framing;
  assign err_len_o      = rpt_q.length;
  assign rpt_len_unused = ^rpt_q.len;

endmodule
